fpga_host_nbf_tx_arbiter: RTL and testbench
===========================================

FPGA_HOST_NBF_TX_ARBITER -- requirements
Module: fpga_host_nbf_tx_arbiter

Interface
REQ-001 Parameter nbf_addr_width_p, default 40, NBF address field width.
REQ-002 Parameter nbf_data_width_p, default 64, NBF data field width.
REQ-003 Parameter nbf_opcode_width_p, default 8, NBF opcode field width.
REQ-004 Derived constant nbf_width_lp = opcode+addr+data (default 112). nbf_bytes_lp = nbf_width_lp/8 (default 14).
REQ-005 Reset is reset, asynchronous, active-low. Clock is clk.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 nbf0_i  in  nbf_width_lp  packet from requester 0 (host echo path).
REQ-009 nbf0_v_i  in  1  requester 0 valid.
REQ-010 nbf0_ready_and_o  out  1  requester 0 ready; a transfer occurs when valid and ready are both high.
REQ-011 nbf1_i, nbf1_v_i, nbf1_ready_and_o: same widths and meanings, for requester 1 (core io-out path).
REQ-012 tx_data_o  out  8  byte to UART TX.
REQ-013 tx_v_o  out  1  byte valid.
REQ-014 tx_ready_and_i  in  1  UART TX ready.
REQ-015 busy_o  out  1  high while a packet is being serialized.
REQ-016 grant_o  out  1  index of the requester whose packet is held; valid while busy_o is high.

Function
REQ-017 The FSM SHALL have two states, e_idle and e_send.
REQ-018 In e_idle, if any nbfN_v_i is high, the block SHALL assert ready for exactly one winner, capture the winner's packet into the holding register, set grant_o, clear byte counter to 0, and go to e_send.
REQ-019 Arbitration SHALL be round-robin. On simultaneous valids, the winner is the requester not granted last. After reset the last grant is 1, so requester 0 wins first.
REQ-020 nbfN_ready_and_o SHALL be high only in e_idle and only for the winner. It may depend combinationally on the valid inputs, never on tx_ready_and_i.
REQ-021 In e_send, tx_v_o SHALL be 1 and tx_data_o SHALL be holding[8*cnt +: 8]. Bytes go LSB-first: byte 0 is the opcode low byte.
REQ-022 Byte counter: 4 bits, range 0..nbf_bytes_lp-1. It SHALL advance only on a tx_v_o && tx_ready_and_i handshake.
REQ-023 On the handshake of byte nbf_bytes_lp-1, the FSM SHALL return to e_idle and record the current grant as the last grant.
REQ-024 Latency: packet accepted in cycle N gives tx_v_o=1 in cycle N+1. The next packet can be accepted no earlier than the cycle after the last-byte handshake (one idle cycle between packets).
REQ-025 A packet SHALL be atomic: no interleaving of bytes from two requesters. Valids arriving during e_send are ignored (ready=0) until e_idle.
REQ-026 tx_ready_and_i held low SHALL stall indefinitely with tx_data_o stable.
REQ-027 In e_idle, tx_v_o=0 and tx_data_o=0.
REQ-028 Valid asserted by a non-winner SHALL NOT be lost; the requester must hold valid until it sees ready.

Reset
REQ-029 Asserting reset SHALL immediately (asynchronously) force: e_idle, tx_v_o=0, tx_data_o=0, busy_o=0, grant_o=0, both ready outputs 0, counter=0, last grant=1.
REQ-030 A packet in flight when reset asserts SHALL be discarded. No bytes of it are emitted after reset deasserts.

Structure
REQ-031 The NBF struct and the derived byte-count constant SHALL live in bp_fpga_host_pkg, beside the existing NBF opcode enum.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 Round-robin selection SHALL be a single sub-module, fpga_host_rr_arb, with 2 requesters, a one-hot grant, and a last-grant update input.

Verification
REQ-034 Single packet: nbf0 = {opcode 0x02, addr 0x80_0000_0000, data 0x1122334455667788}, tx_ready always 1 -> 14 bytes, 02 00 00 00 00 80 88 77 66 55 44 33 22 11, on consecutive cycles starting N+1.
REQ-035 Simultaneous valids right after reset, nbf0 opcode 0xA0 and nbf1 opcode 0xB1 -> all 14 bytes of A0 first, then all 14 bytes of B1. grant_o is 0 then 1.
REQ-036 Back-pressure: tx_ready toggled 1-in-3 during the REQ-034 packet -> the same 14-byte sequence, with tx_data_o stable during stalls.
REQ-037 Fairness: both requesters hold valid for 6 packets -> grants alternate 0,1,0,1,0,1, and no byte interleaving occurs within any packet.
REQ-038 Reset asserted after byte 5 of a packet -> tx_v_o drops in the same cycle. After release, with no valids, tx_v_o stays 0 for 100 cycles.
REQ-039 nbf1 valid during nbf0 serialization -> nbf1_ready_and_o stays 0 until e_idle. nbf1 is then accepted with one idle cycle after nbf0's last byte.

Source files
------------

// File: rtl/bp_fpga_host_pkg.sv
// Shared FPGA host definitions: NBF opcodes, the NBF packet layout and
// the helpers used to size the byte serializer.
package bp_fpga_host_pkg;

  localparam int nbf_opcode_width_gp = 8;
  localparam int nbf_addr_width_gp   = 40;
  localparam int nbf_data_width_gp   = 64;
  localparam int nbf_width_gp        = nbf_opcode_width_gp + nbf_addr_width_gp + nbf_data_width_gp;
  localparam int nbf_cnt_width_gp    = 4;

  typedef enum logic [7:0] {
    e_bp_nbf_wr_4   = 8'h02,
    e_bp_nbf_wr_8   = 8'h03,
    e_bp_nbf_rd_4   = 8'h12,
    e_bp_nbf_rd_8   = 8'h13,
    e_bp_nbf_fence  = 8'hFE,
    e_bp_nbf_finish = 8'hFF
  } bp_fpga_host_nbf_opcode_e;

  // Opcode sits in the low bits so it is the first byte on the wire
  typedef struct packed {
    logic [nbf_data_width_gp-1:0]   data;
    logic [nbf_addr_width_gp-1:0]   addr;
    logic [nbf_opcode_width_gp-1:0] opcode;
  } bp_fpga_host_nbf_s;

  function automatic int nbf_bytes_f(input int width);
    return width / 8;
  endfunction

  localparam int nbf_bytes_gp = nbf_bytes_f(nbf_width_gp);

endpackage

// File: rtl/fpga_host_rr_arb.sv
// Two-requester round-robin arbiter; the last grant only moves when the
// owner reports that its packet has been fully consumed.
module fpga_host_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reqs_i,
  output logic [1:0] grants_o,
  input  logic       update_v_i,
  input  logic       update_idx_i
);

  logic last_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (update_v_i) begin
      last_r <= update_idx_i;
    end
  end

  // On a tie the requester that was not served last wins
  always_comb begin
    grants_o = reqs_i;
    if (reqs_i == 2'b11) begin
      grants_o = last_r ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fpga_host_nbf_tx_arbiter.sv
// Merges two NBF packet streams onto the UART TX byte stream, serializing one
// whole packet at a time, least-significant byte first.
module fpga_host_nbf_tx_arbiter
  import bp_fpga_host_pkg::*;
  #(parameter int nbf_addr_width_p = 40
    , parameter int nbf_data_width_p = 64
    , parameter int nbf_opcode_width_p = 8
    , localparam int nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p
    , localparam int nbf_bytes_lp = nbf_bytes_f(nbf_width_lp)
    )
  (input  logic                    clk,
   input  logic                    reset,
   input  logic [nbf_width_lp-1:0] nbf0_i,
   input  logic                    nbf0_v_i,
   output logic                    nbf0_ready_and_o,
   input  logic [nbf_width_lp-1:0] nbf1_i,
   input  logic                    nbf1_v_i,
   output logic                    nbf1_ready_and_o,
   output logic [7:0]              tx_data_o,
   output logic                    tx_v_o,
   input  logic                    tx_ready_and_i,
   output logic                    busy_o,
   output logic                    grant_o
   );

  typedef enum logic {e_idle, e_send} state_e;

  localparam logic [nbf_cnt_width_gp-1:0] last_cnt_lp = nbf_cnt_width_gp'(nbf_bytes_lp - 1);

  state_e                         state_r, state_n;
  logic [nbf_bytes_lp-1:0][7:0]   holding_r, winner_pkt;
  logic [nbf_cnt_width_gp-1:0]    cnt_r, cnt_n;
  logic                           grant_r;
  logic [1:0]                     arb_grants;
  logic                           accept, tx_done;

  fpga_host_rr_arb arb (
    .clk          (clk),
    .reset        (reset),
    .reqs_i       ({nbf1_v_i, nbf0_v_i}),
    .grants_o     (arb_grants),
    .update_v_i   (tx_done),
    .update_idx_i (grant_r)
  );

  assign winner_pkt = arb_grants[1] ? nbf1_i : nbf0_i;

  // Ready is gated by reset so nothing is handed over while reset is held
  always_comb begin
    state_n          = state_r;
    cnt_n            = cnt_r;
    nbf0_ready_and_o = 1'b0;
    nbf1_ready_and_o = 1'b0;
    tx_v_o           = 1'b0;
    tx_data_o        = '0;
    busy_o           = 1'b0;
    accept           = 1'b0;
    tx_done          = 1'b0;
    case (state_r)
      e_idle: begin
        nbf0_ready_and_o = reset & arb_grants[0];
        nbf1_ready_and_o = reset & arb_grants[1];
        accept           = nbf0_ready_and_o | nbf1_ready_and_o;
        if (accept) begin
          state_n = e_send;
          cnt_n   = '0;
        end
      end
      e_send: begin
        tx_v_o    = 1'b1;
        tx_data_o = holding_r[cnt_r];
        busy_o    = 1'b1;
        if (tx_ready_and_i) begin
          if (cnt_r == last_cnt_lp) begin
            tx_done = 1'b1;
            state_n = e_idle;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= e_idle;
      cnt_r     <= '0;
      holding_r <= '0;
      grant_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (accept) begin
        holding_r <= winner_pkt;
        grant_r   <= arb_grants[1];
      end
    end
  end

  assign grant_o = grant_r;

endmodule

// File: tb/tb_fpga_host_nbf_tx_arbiter.sv
// Directed bench for the NBF TX arbiter: byte order, round-robin fairness,
// back-pressure, idle gap between packets and asynchronous reset.
module tb_fpga_host_nbf_tx_arbiter;
  import bp_fpga_host_pkg::*;

  logic         clk;
  logic         reset;
  logic [111:0] nbf0_i, nbf1_i;
  logic         nbf0_v_i, nbf1_v_i;
  logic         nbf0_ready_and_o, nbf1_ready_and_o;
  logic [7:0]   tx_data_o;
  logic         tx_v_o;
  logic         tx_ready_and_i;
  logic         busy_o;
  logic         grant_o;

  int checks = 0;
  int errors = 0;

  fpga_host_nbf_tx_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .nbf0_i           (nbf0_i),
    .nbf0_v_i         (nbf0_v_i),
    .nbf0_ready_and_o (nbf0_ready_and_o),
    .nbf1_i           (nbf1_i),
    .nbf1_v_i         (nbf1_v_i),
    .nbf1_ready_and_o (nbf1_ready_and_o),
    .tx_data_o        (tx_data_o),
    .tx_v_o           (tx_v_o),
    .tx_ready_and_i   (tx_ready_and_i),
    .busy_o           (busy_o),
    .grant_o          (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual=running, required=finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [111:0] p0,
                               input logic v1, input logic [111:0] p1);
    nbf0_v_i = v0;
    nbf0_i   = p0;
    nbf1_v_i = v1;
    nbf1_i   = p1;
  endtask

  function automatic logic [111:0] mkPkt(input logic [7:0] op, input logic [39:0] addr,
                                         input logic [63:0] data);
    bp_fpga_host_nbf_s s;
    s.opcode = op;
    s.addr   = addr;
    s.data   = data;
    return s;
  endfunction

  // Called at the negedge right after acceptance; consumes nbytes bytes
  task automatic drainPacket(input logic [111:0] pkt, input logic exp_grant, input bit bp,
                             input int nbytes, input string tag);
    int b   = 0;
    int cyc = 0;
    while (b < nbytes && cyc < 200) begin
      checkOutput({tag, "_v"}, tx_v_o, 1);
      checkOutput({tag, "_byte"}, tx_data_o, pkt[8*b +: 8]);
      checkOutput({tag, "_busy"}, busy_o, 1);
      checkOutput({tag, "_grant"}, grant_o, exp_grant);
      checkOutput({tag, "_rdy0"}, nbf0_ready_and_o, 0);
      checkOutput({tag, "_rdy1"}, nbf1_ready_and_o, 0);
      tx_ready_and_i = bp ? (cyc % 3 == 2) : 1'b1;
      if (tx_ready_and_i) b++;
      cyc++;
      @(negedge clk);
    end
    checkOutput({tag, "_count"}, b, nbytes);
    if (nbytes == 14) begin
      checkOutput({tag, "_idle_v"}, tx_v_o, 0);
      checkOutput({tag, "_idle_data"}, tx_data_o, 0);
      checkOutput({tag, "_idle_busy"}, busy_o, 0);
    end
    tx_ready_and_i = 1'b1;
  endtask

  logic [111:0] pkt_a, pkt_a0, pkt_b1, pkt_c, pkt_d, p0, p1;
  int           n0, n1, vcount;
  logic         exp_g;

  initial begin
    pkt_a  = 112'h1122334455667788_8000000000_02;
    pkt_a0 = mkPkt(8'hA0, 40'h00_0000_1000, 64'h0102030405060708);
    pkt_b1 = mkPkt(8'hB1, 40'h00_0000_2000, 64'hF1F2F3F4F5F6F7F8);
    pkt_c  = mkPkt(8'h03, 40'h12_3456_789A, 64'hDEADBEEFCAFEF00D);
    pkt_d  = mkPkt(8'h13, 40'hAB_CDEF_0123, 64'h0011223344556677);

    reset          = 1'b0;
    tx_ready_and_i = 1'b1;
    applyStimulus(0, '0, 0, '0);
    #2;
    checkOutput("rst_v", tx_v_o, 0);
    checkOutput("rst_data", tx_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_grant", grant_o, 0);
    applyStimulus(1, pkt_a, 1, pkt_b1);
    #1;
    checkOutput("rst_rdy0", nbf0_ready_and_o, 0);
    checkOutput("rst_rdy1", nbf1_ready_and_o, 0);
    applyStimulus(0, '0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single packet from requester 0");
    applyStimulus(1, pkt_a, 0, '0);
    #1;
    checkOutput("single_rdy0", nbf0_ready_and_o, 1);
    checkOutput("single_rdy1", nbf1_ready_and_o, 0);
    checkOutput("single_pre_v", tx_v_o, 0);
    @(negedge clk);
    applyStimulus(0, pkt_a, 0, '0);
    drainPacket(pkt_a, 0, 0, 14, "single");

    $display("[TB] simultaneous valids right after reset");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1, pkt_a0, 1, pkt_b1);
    #1;
    checkOutput("tie_rdy0", nbf0_ready_and_o, 1);
    checkOutput("tie_rdy1", nbf1_ready_and_o, 0);
    @(negedge clk);
    applyStimulus(0, pkt_a0, 1, pkt_b1);
    drainPacket(pkt_a0, 0, 0, 14, "tie_a0");
    #1;
    checkOutput("tie_gap_rdy1", nbf1_ready_and_o, 1);
    checkOutput("tie_gap_rdy0", nbf0_ready_and_o, 0);
    @(negedge clk);
    applyStimulus(0, pkt_a0, 0, pkt_b1);
    drainPacket(pkt_b1, 1, 0, 14, "tie_b1");

    $display("[TB] back-pressure, ready one cycle in three");
    applyStimulus(1, pkt_a, 0, '0);
    #1;
    checkOutput("bp_rdy0", nbf0_ready_and_o, 1);
    @(negedge clk);
    applyStimulus(0, pkt_a, 0, '0);
    drainPacket(pkt_a, 0, 1, 14, "bp");

    $display("[TB] reset in the middle of a packet");
    applyStimulus(1, pkt_a, 0, '0);
    #1;
    @(negedge clk);
    applyStimulus(0, pkt_a, 0, '0);
    drainPacket(pkt_a, 0, 0, 6, "midrst");
    checkOutput("midrst_byte6", tx_data_o, 8'h88);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_v", tx_v_o, 0);
    checkOutput("midrst_data", tx_data_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    nbf0_v_i = 1'b1;
    #1;
    checkOutput("midrst_rdy0", nbf0_ready_and_o, 0);
    nbf0_v_i = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_v_o) vcount++;
    end
    checkOutput("midrst_quiet", vcount, 0);

    $display("[TB] requester 1 arrives during requester 0 serialization");
    applyStimulus(1, pkt_c, 0, pkt_d);
    #1;
    checkOutput("late_rdy0", nbf0_ready_and_o, 1);
    @(negedge clk);
    applyStimulus(0, pkt_c, 1, pkt_d);
    drainPacket(pkt_c, 0, 0, 14, "late_c");
    #1;
    checkOutput("late_gap_rdy1", nbf1_ready_and_o, 1);
    @(negedge clk);
    applyStimulus(0, pkt_c, 0, pkt_d);
    drainPacket(pkt_d, 1, 0, 14, "late_d");

    $display("[TB] fairness with both requesters always valid");
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 6; k++) begin
      exp_g = k[0];
      p0 = mkPkt(8'h10 + 8'(n0), 40'h10_0000_0000 + 40'(n0), 64'hA5A5_0000_0000_0000 + 64'(n0));
      p1 = mkPkt(8'h20 + 8'(n1), 40'h20_0000_0000 + 40'(n1), 64'h5A5A_0000_0000_0000 + 64'(n1));
      applyStimulus(1, p0, 1, p1);
      #1;
      checkOutput("fair_rdy0", nbf0_ready_and_o, !exp_g);
      checkOutput("fair_rdy1", nbf1_ready_and_o, exp_g);
      @(negedge clk);
      drainPacket(exp_g ? p1 : p0, exp_g, 0, 14, "fair");
      if (exp_g) n1++;
      else n0++;
    end
    applyStimulus(0, '0, 0, '0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
